store_buffer: RTL

- Write buffer between the EXE/MEM pipeline register and the negedge-sampled data memory.
- Posts stores into a small FIFO so they do not occupy the memory port in the issuing cycle.
- Drains buffered stores to memory when the port is free.
- Loads have port priority; a load that hits a buffered store is served by forwarding from the youngest matching entry.

---
 rtl/store_buffer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Posted-store buffer in front of a negedge-sampled data memory.
// Loads win the memory port; load hits are forwarded from the youngest matching entry.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_wr,
    input  logic             req_rd,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic             flush,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    output logic             flush_done,
    output logic [PTR_W:0]   count,
    output logic [31:0]      mem_adr,
    output logic [31:0]      mem_wdata,
    output logic             mem_w_en,
    output logic             mem_r_en,
    input  logic [31:0]      mem_rdata
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] COUNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [31:0]      entry_addr [DEPTH];
    logic [31:0]      entry_data [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic [31:0]      rd_data_reg;
    logic             rd_valid_reg;

    logic [DEPTH-1:0] match;
    logic [DEPTH-1:0] age_match;
    logic [PTR_W-1:0] age_slot [DEPTH];
    logic             entry_hit;
    logic [PTR_W-1:0] hit_idx;
    logic             load_hit;
    logic             load_miss;
    logic             drain;
    logic             enq;
    logic             empty;
    logic             full;

    // age_slot[gi] is the slot gi positions younger than head, so a higher gi is a younger store
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign match[gi]     = valid_reg[gi] && (entry_addr[gi] == req_addr);
        assign age_slot[gi]  = head_reg + PTR_W'(gi);
        assign age_match[gi] = match[age_slot[gi]];
    end

    always_comb begin
        entry_hit = 1'b0;
        hit_idx   = head_reg;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_match[i]) begin
                entry_hit = 1'b1;
                hit_idx   = age_slot[i];
            end
        end
    end

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == FULL_COUNT);
    assign load_hit  = req_rd && entry_hit;
    assign load_miss = req_rd && !entry_hit;
    assign drain     = !load_miss && !empty;
    // A full buffer can only accept a store in a cycle that also frees the head slot
    assign enq       = req_wr && (!full || drain);

    always_comb begin
        count_next = count_reg;
        if (enq && !drain) begin
            count_next = count_reg + COUNT_ONE;
        end else if (!enq && drain) begin
            count_next = count_reg - COUNT_ONE;
        end
    end

    always_comb begin
        mem_r_en  = load_miss;
        mem_w_en  = drain;
        mem_adr   = '0;
        mem_wdata = '0;
        if (load_miss) begin
            mem_adr = req_addr;
        end else if (drain) begin
            mem_adr   = entry_addr[head_reg];
            mem_wdata = entry_data[head_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            entry_addr[tail_reg] <= req_addr;
            entry_data[tail_reg] <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            valid_reg    <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            // Clear before set: when full, the drained slot is the one being refilled
            if (drain) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + PTR_ONE;
            end
            if (enq) begin
                valid_reg[tail_reg] <= 1'b1;
                tail_reg            <= tail_reg + PTR_ONE;
            end
            count_reg    <= count_next;
            rd_valid_reg <= req_rd;
            if (load_hit) begin
                rd_data_reg <= entry_data[hit_idx];
            end else if (load_miss) begin
                rd_data_reg <= mem_rdata;
            end
        end
    end

    assign rd_data    = rd_data_reg;
    assign rd_valid   = rd_valid_reg;
    assign count      = count_reg;
    assign flush_done = flush && empty;

endmodule
